seq_pattern_detect: RTL



---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_sat_counter.sv | 20 ++
 rtl/seq_pattern_detect.sv | 94 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Length clamping lives here so every user applies identical rules.
package seq_det_pkg;

    localparam int         PAT_W_DEF   = 4;
    localparam logic [3:0] DEF_PAT_DEF = 4'b0101;
    localparam int         CNT_W_DEF   = 8;

    // A length of zero or one longer than the pattern register means "use all bits".
    function automatic int clamp_len(input int len, input int pat_w);
        if (len == 0 || len > pat_w)
            return pat_w;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// W-bit counter that increments on inc and sticks at all-ones.
module seq_det_sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/seq_pattern_detect.sv
// Runtime-programmable serial pattern detector with Mealy and registered flags.
// Define SEQ_DET_COUNT_EN to include the saturating match counter.
module seq_pattern_detect
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_DEF),
    parameter int               CNT_W   = CNT_W_DEF,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             detect,
    output logic             detect_q,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

    logic [PAT_W-1:0] act_pat;
    logic [LEN_W-1:0] act_len;
    logic             act_ovl;
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] len_m1;
    logic             fill_ok;
    logic             bits_match;

    assign window = {hist, din};
    assign len_m1 = act_len - LEN_W'(1);

    // Only the newest act_len bits of the window take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(act_len))
                len_mask[i] = 1'b1;
        end
    end

    assign bits_match = (((window ^ act_pat) & len_mask) == '0);
    assign fill_ok    = (fill >= len_m1);
    assign detect     = ~reset & din_valid & ~cfg_load & fill_ok & bits_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_pat  <= DEF_PAT;
            act_len  <= LEN_W'(PAT_W);
            act_ovl  <= 1'b1;
            hist     <= '0;
            fill     <= '0;
            detect_q <= 1'b0;
        end else begin
            detect_q <= detect;
            if (cfg_load) begin
                act_pat <= cfg_pattern;
                act_len <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
                act_ovl <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (din_valid) begin
                hist <= window[PAT_W-2:0];
                // Non-overlapping mode forces the next match to start from fresh bits.
                if (detect && !act_ovl)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + LEN_W'(1);
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    seq_det_sat_counter #(
        .W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (detect),
        .count(match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
